// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA1 message front end: padder states and
// block-geometry constants.
package sha1_pkg;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_PAD,
    ST_PAD2,
    ST_ISSUE,
    ST_WAIT
  } sha1_state_e;

  localparam int          SHA1_BLOCK_BYTES = 64;
  localparam int          SHA1_LEN_OFS     = 56;
  localparam logic [7:0]  SHA1_PAD_BYTE    = 8'h80;
  localparam int          SHA1_LEN_W       = 64;

endpackage

// File: rtl/sha1_padder.sv
// Byte-stream to padded 512-bit block front end for the SHA1 core: fills a
// 64-byte buffer, appends 0x80/zeros/bit length, and hands blocks over by start/done.
module sha1_padder
  import sha1_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic         start,
  output logic [0:511] block,
  output logic         first,
  output logic         final_blk,
  input  logic         done,
  output logic         msg_done
);

  localparam int IDX_W = 7;

  sha1_state_e     state_q;
  logic [7:0]      buf_q [SHA1_BLOCK_BYTES];
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic            pad_pending_q;
  logic            msg_end_q;
  logic            start_q;
  logic            first_q;
  logic            final_q;
  logic            msg_done_q;
  logic [SHA1_LEN_W-1:0] len_d;

  assign len_d = SHA1_LEN_W'(cnt_q) << 3;

  assign in_ready  = (state_q == ST_FILL) && !rst;
  assign start     = start_q;
  assign first     = first_q;
  assign final_blk = final_q;
  assign msg_done  = msg_done_q;

  for (genvar g = 0; g < SHA1_BLOCK_BYTES; g++) begin : g_block
    assign block[8*g +: 8] = buf_q[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FILL;
      // NOTE: the buffer is reset because an all-zero block is the required
      // post-reset output and the base every padded block is built on.
      for (int i = 0; i < SHA1_BLOCK_BYTES; i++) buf_q[i] <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      pad_pending_q <= 1'b0;
      msg_end_q     <= 1'b0;
      start_q       <= 1'b0;
      first_q       <= 1'b1;
      final_q       <= 1'b0;
      msg_done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; the pulse defaults below are overridden
      // by later assignments in the same edge, last write wins.
      start_q    <= 1'b0;
      msg_done_q <= 1'b0;
      unique case (state_q)
        ST_FILL: begin
          if (in_valid) begin
            buf_q[idx_q[5:0]] <= in_data;
            idx_q <= idx_q + IDX_W'(1);
            cnt_q <= cnt_q + CNT_W'(1);
            if (in_last) begin
              state_q <= ST_PAD;
            end else if (idx_q == IDX_W'(SHA1_BLOCK_BYTES - 1)) begin
              final_q <= 1'b0;
              start_q <= 1'b1;
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_PAD: begin
          if (idx_q < IDX_W'(SHA1_BLOCK_BYTES)) begin
            buf_q[idx_q[5:0]] <= SHA1_PAD_BYTE;
            pad_pending_q     <= 1'b0;
          end else begin
            pad_pending_q <= 1'b1;
          end
          // Length only fits when the message plus 0x80 leaves bytes 56..63 free.
          if (idx_q <= IDX_W'(SHA1_LEN_OFS - 1)) begin
            for (int k = 0; k < 8; k++) buf_q[SHA1_LEN_OFS + k] <= len_d[8*(7-k) +: 8];
            final_q <= 1'b1;
          end else begin
            msg_end_q <= 1'b1;
          end
          start_q <= 1'b1;
          state_q <= ST_ISSUE;
        end
        ST_PAD2: begin
          if (pad_pending_q) buf_q[0] <= SHA1_PAD_BYTE;
          for (int k = 0; k < 8; k++) buf_q[SHA1_LEN_OFS + k] <= len_d[8*(7-k) +: 8];
          pad_pending_q <= 1'b0;
          final_q       <= 1'b1;
          start_q       <= 1'b1;
          state_q       <= ST_ISSUE;
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done) begin
            for (int i = 0; i < SHA1_BLOCK_BYTES; i++) buf_q[i] <= '0;
            idx_q <= '0;
            if (final_q) begin
              msg_done_q <= 1'b1;
              cnt_q      <= '0;
              first_q    <= 1'b1;
              final_q    <= 1'b0;
              msg_end_q  <= 1'b0;
              state_q    <= ST_FILL;
            end else begin
              first_q <= 1'b0;
              state_q <= msg_end_q ? ST_PAD2 : ST_FILL;
            end
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_padder.sv
// Self-checking bench for sha1_padder: directed boundary messages plus random
// messages compared against a byte-queue padding model.
module tb_sha1_padder;

  localparam int BUDGET = 2000;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic         start;
  logic [0:511] block;
  logic         first;
  logic         final_blk;
  logic         done;
  logic         msg_done;

  logic core_done = 1'b0;
  logic man_done  = 1'b0;
  assign done = core_done | man_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sha1_padder #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .start(start), .block(block),
    .first(first), .final_blk(final_blk), .done(done), .msg_done(msg_done)
  );

  typedef struct {
    logic [0:511] blk;
    logic         fst;
    logic         fin;
    int           lag;
  } cap_t;

  cap_t       caps[$];
  cap_t       exp_q[$];
  logic [7:0] msg[$];

  int cyc = 0, done_edge = 0, start_cnt = 0, msg_done_cnt = 0, msg_done_lag = 0;
  bit core_en = 1'b1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_edge <= cyc + 1;
  end

  always @(negedge clk) begin
    if (start) begin
      caps.push_back('{block, first, final_blk, cyc - done_edge});
      start_cnt <= start_cnt + 1;
    end
    if (msg_done) begin
      msg_done_cnt <= msg_done_cnt + 1;
      msg_done_lag <= cyc - done_edge;
    end
  end

  // Core stand-in: answers each start with a one-cycle done after 1..4 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (start && core_en) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Padding rules applied to the whole message, then cut into 64-byte blocks.
  task automatic model();
    logic [7:0]  p[$];
    logic [63:0] len;
    int          nblk;
    exp_q.delete();
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    len = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(len[8*k +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      cap_t e;
      for (int i = 0; i < 64; i++) e.blk[8*i +: 8] = p[64*b + i];
      e.fst = (b == 0);
      e.fin = (b == nblk - 1);
      e.lag = 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input string tag);
    for (int i = 0; i < msg.size(); i++) begin
      int b = 0;
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_data  = msg[i];
      in_valid = 1'b1;
      in_last  = (i == msg.size() - 1);
      while (!in_ready && b < BUDGET) begin
        @(negedge clk);
        b++;
      end
      if (b >= BUDGET) begin
        check({tag, "_ready_timeout"}, b, 0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_msg_done(input string tag, input int md0);
    int b = 0;
    while (msg_done_cnt == md0 && b < BUDGET) begin
      @(negedge clk);
      b++;
    end
    check({tag, "_msg_done_seen"}, msg_done_cnt - md0, 1);
  endtask

  task automatic wait_start(input string tag, input int s0);
    int b = 0;
    while (start_cnt == s0 && b < BUDGET) begin
      @(negedge clk);
      b++;
    end
    check({tag, "_start_seen"}, start_cnt - s0, 1);
  endtask

  task automatic run_msg(input string tag);
    int md0;
    int n;
    md0 = msg_done_cnt;
    caps.delete();
    model();
    send(tag);
    wait_msg_done(tag, md0);
    check({tag, "_nblocks"}, caps.size(), exp_q.size());
    n = (caps.size() < exp_q.size()) ? caps.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_blk%0d", tag, i), caps[i].blk, exp_q[i].blk);
      check($sformatf("%s_first%0d", tag, i), caps[i].fst, exp_q[i].fst);
      check($sformatf("%s_final%0d", tag, i), caps[i].fin, exp_q[i].fin);
    end
  endtask

  task automatic set_fill(input int n, input logic [7:0] v);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(v);
  endtask

  task automatic set_test();
    msg = '{8'h74, 8'h65, 8'h73, 8'h74};
  endtask

  initial begin
    logic [0:511] t_exp;
    logic [0:511] snap;
    int           s0, md0, bad;

    t_exp          = '0;
    t_exp[0:39]    = 40'h74_65_73_74_80;
    t_exp[504:511] = 8'h20;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_start", start, 0);
    check("rst_block", block, '0);
    check("rst_first", first, 1);
    check("rst_final", final_blk, 0);
    check("rst_msg_done", msg_done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    set_test();
    run_msg("test");
    if (caps.size() > 0) check("test_const_block", caps[0].blk, t_exp);
    check("test_msg_done_lag", msg_done_lag, 0);

    set_fill(55, 8'h61);
    run_msg("len55");
    set_fill(56, 8'h61);
    run_msg("len56");
    set_fill(64, 8'h61);
    run_msg("len64");
    if (caps.size() > 1) check("len64_pad2_lag", caps[1].lag, 1);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 200);
      msg.delete();
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(0, 255)));
      run_msg($sformatf("rand%0d_len%0d", r, n));
    end

    // Stall: core holds off done for 100 cycles.
    core_en = 1'b0;
    set_test();
    caps.delete();
    s0 = start_cnt;
    send("stall");
    wait_start("stall", s0);
    snap = block;
    bad  = 0;
    repeat (100) begin
      @(negedge clk);
      if (block !== snap || in_ready !== 1'b0 || final_blk !== 1'b1 || first !== 1'b1) bad++;
    end
    check("stall_stable", bad, 0);
    check("stall_one_start", start_cnt - s0, 1);
    check("stall_block", snap, t_exp);
    md0 = msg_done_cnt;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    wait_msg_done("stall", md0);

    // done while idle in FILL must be ignored.
    s0  = start_cnt;
    md0 = msg_done_cnt;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (5) @(negedge clk);
    check("fill_done_no_start", start_cnt - s0, 0);
    check("fill_done_no_msg_done", msg_done_cnt - md0, 0);
    check("fill_done_in_ready", in_ready, 1);

    // Reset while waiting on the second (non-first) block of a 100-byte message.
    core_en = 1'b1;
    set_fill(100, 8'h5a);
    s0 = start_cnt;
    send("abort");
    core_en = 1'b0;
    wait_start("abort2", s0 + 1);
    check("abort_first_cleared", first, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("wait_rst_in_ready", in_ready, 0);
    check("wait_rst_start", start, 0);
    check("wait_rst_block", block, '0);
    check("wait_rst_first", first, 1);
    check("wait_rst_final", final_blk, 0);
    check("wait_rst_msg_done", msg_done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("wait_post_rst_in_ready", in_ready, 1);
    core_en = 1'b1;
    set_test();
    run_msg("after_rst");
    if (caps.size() > 0) begin
      check("after_rst_const_block", caps[0].blk, t_exp);
      check("after_rst_first", caps[0].fst, 1);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
